// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer engine: FSM state encoding and
// SCLK polarity/phase mode constants.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic CPOL_IDLE_LOW     = 1'b0;
  localparam logic CPOL_IDLE_HIGH    = 1'b1;
  localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
  localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: counts CLK_DIV-cycle half periods while enabled and flags the
// leading and trailing SCLK edges of each bit period during the shift phase.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int   CLK_DIV = 2,
  parameter logic CPOL    = CPOL_IDLE_LOW
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic shift,
  output logic half_end,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  logic [DIV_W-1:0] div_cnt;
  logic             phase;

  assign half_end   = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign lead_edge  = shift && half_end && !phase;
  assign trail_edge = shift && half_end && phase;
  // phase is 1 only in the active (non-idle) half of a bit period
  assign sclk       = CPOL ^ phase;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      div_cnt <= half_end ? '0 : div_cnt + DIV_W'(1);
      if (shift && half_end) phase <= !phase;
    end
  end

endmodule

// File: rtl/spi_xfer_engine.sv
// Single-word SPI master: LEAD/SHIFT/TRAIL framing around DATA_W bit periods.
// Define SPI_XFER_CS_EN to add an active-low chip-select output CS_N.
module spi_xfer_engine
  import spi_pkg::*;
#(
  parameter int   DATA_W  = 8,
  parameter int   CLK_DIV = 2,
  parameter logic CPOL    = CPOL_IDLE_LOW,
  parameter logic CPHA    = CPHA_SAMPLE_LEAD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              W_STB,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_RDY,
  output logic              R_STB,
  output logic [DATA_W-1:0] R_DATA,
  output logic              BUSY,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
`ifdef SPI_XFER_CS_EN
  ,
  output logic              CS_N
`endif
);

  localparam int BIT_W = $clog2(DATA_W) + 1;

  state_t            state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              mosi_q;
  logic              gen_en, in_shift, half_end, lead_edge, trail_edge;
  logic              accept, last_bit;

  assign gen_en   = (state == LEAD) || (state == SHIFT) || (state == TRAIL);
  assign in_shift = (state == SHIFT);
  assign accept   = (state == IDLE) && W_STB;
  assign last_bit = (bit_cnt == BIT_W'(DATA_W - 1));
  assign BUSY     = !W_RDY;
  assign MOSI     = mosi_q;
`ifdef SPI_XFER_CS_EN
  assign CS_N     = !gen_en;
`endif

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .CLK        (CLK),
    .RST        (RST),
    .en         (gen_en),
    .shift      (in_shift),
    .half_end   (half_end),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sclk       (SCLK)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    W_RDY     = 1'b0;
    R_STB     = 1'b0;
    case (state)
      IDLE: begin
        W_RDY = 1'b1;
        if (W_STB) state_nxt = LEAD;
      end
      LEAD:    if (half_end) state_nxt = SHIFT;
      SHIFT:   if (trail_edge && last_bit) state_nxt = TRAIL;
      TRAIL:   if (half_end) state_nxt = DONE;
      DONE: begin
        R_STB     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath; MOSI parks high outside the bit periods
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      mosi_q  <= 1'b1;
      R_DATA  <= '0;
    end else begin
      if (accept) begin
        tx_sr   <= W_DATA;
        rx_sr   <= '0;
        bit_cnt <= '0;
        mosi_q  <= (CPHA == CPHA_SAMPLE_LEAD) ? W_DATA[DATA_W-1] : 1'b1;
      end
      if (lead_edge) begin
        if (CPHA == CPHA_SAMPLE_LEAD) begin
          rx_sr <= {rx_sr[DATA_W-2:0], MISO};
        end else begin
          mosi_q <= tx_sr[DATA_W-1];
          tx_sr  <= tx_sr << 1;
        end
      end
      if (trail_edge) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
        if (CPHA == CPHA_SAMPLE_LEAD) begin
          tx_sr  <= tx_sr << 1;
          mosi_q <= last_bit ? 1'b1 : tx_sr[DATA_W-2];
        end else begin
          rx_sr <= {rx_sr[DATA_W-2:0], MISO};
          if (last_bit) mosi_q <= 1'b1;
        end
      end
      if ((state == TRAIL) && half_end) R_DATA <= rx_sr;
    end
  end

endmodule

// File: doc/spi_xfer_engine.md
SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 8, word width in bits; legal range 2..32.
- CLK_DIV, 2, CLK cycles per SCLK half-period; minimum 1.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock; all logic on posedge.
- RST, in, 1, asynchronous active-high reset.
- W_STB, in, 1, start request.
- W_DATA, in, DATA_W, transmit word.
- W_RDY, out, 1, engine idle; a request is accepted.
- R_STB, out, 1, one-cycle pulse: word complete.
- R_DATA, out, DATA_W, received word, held until next R_STB.
- BUSY, out, 1, transfer in progress.
- SCLK, out, 1, serial clock.
- MOSI, out, 1, serial data out.
- MISO, in, 1, serial data in.

Function
REQ-003 The FSM SHALL have states IDLE, LEAD, SHIFT, TRAIL and DONE.
REQ-004 In IDLE, W_RDY SHALL be 1. A cycle with W_STB=1 SHALL latch W_DATA and move to LEAD.
REQ-005 W_STB outside IDLE SHALL be ignored, with no queuing and no effect on the current transfer.
REQ-006 LEAD SHALL last CLK_DIV cycles with SCLK=CPOL.
- If CPHA=0, MOSI SHALL present the MSB from LEAD entry.
REQ-007 SHIFT SHALL produce exactly DATA_W SCLK periods of 2*CLK_DIV cycles each, starting at the CPOL level.
REQ-008 Bit order SHALL be MSB first.
- CPHA=0: MISO sampled on the leading edge; MOSI advances on the trailing edge.
- CPHA=1: MOSI advances on the leading edge; MISO sampled on the trailing edge.
REQ-009 TRAIL SHALL last CLK_DIV cycles with SCLK=CPOL, then go to DONE.
REQ-010 DONE SHALL last one cycle with R_STB=1 and R_DATA updated in that same cycle, then return to IDLE.
REQ-011 Latency: with the accept cycle as cycle 0, R_STB SHALL be high in cycle (2*DATA_W+2)*CLK_DIV+1.
REQ-012 MOSI SHALL be 1 in IDLE, TRAIL and DONE.
REQ-013 BUSY SHALL equal NOT W_RDY.
REQ-014 Divider and bit counters SHALL be sized $clog2 of their maximum count plus 1, and SHALL NOT wrap within a transfer.

Reset
REQ-015 While RST=1, asynchronously:
- state = IDLE, W_RDY = 1, R_STB = 0, R_DATA = 0, BUSY = 0, SCLK = CPOL, MOSI = 1;
- all counters and shift registers = 0.
REQ-016 RST asserted mid-transfer SHALL abort the transfer with no R_STB. The first W_STB after deassertion SHALL start a clean transfer.

Configuration
REQ-017 Macro SPI_XFER_CS_EN governs chip-select generation.
- Defined: output port CS_N (1 bit) SHALL exist. CS_N SHALL be 0 from LEAD entry through the end of TRAIL, and 1 otherwise, including during reset.
- Undefined: port CS_N SHALL be absent and chip select SHALL be handled at top level. All other behaviour SHALL be identical.

Structure
REQ-018 Package spi_pkg SHALL hold the FSM state encoding and the CPOL/CPHA mode constants.
REQ-019 Sub-module spi_clk_gen SHALL hold the CLK_DIV divider, emitting single-cycle lead_edge and trail_edge strobes and the SCLK level. It SHALL be enabled only in LEAD, SHIFT and TRAIL.

Verification
REQ-020 The bench SHALL cover these scenarios:
- DATA_W=8, CLK_DIV=2, mode 0, MISO looped to MOSI, W_DATA=0xA5 -> R_DATA=0xA5; R_STB in cycle 37; exactly 8 SCLK rising edges.
- Mode 3 (CPOL=1, CPHA=1), slave model returns 0x3C, W_DATA=0xC3 -> R_DATA=0x3C; SCLK idles 1; MOSI bits sampled on rising edges read 0xC3.
- W_STB pulsed at cycles 5 and 20 during a transfer -> ignored; single R_STB; MOSI stream unchanged.
- RST raised in cycle 10 of a transfer -> SCLK=CPOL, MOSI=1, W_RDY=1 immediately; no R_STB; next W_STB=0x5A completes correctly.
- DATA_W=16, CLK_DIV=1, W_DATA=0xBEEF loopback -> R_DATA=0xBEEF in cycle 35.
- SPI_XFER_CS_EN defined -> CS_N falls at LEAD entry and rises at DONE entry. Undefined -> the build elaborates with no CS_N port.
